// File: rtl/icache_line.sv
// icache_line: direct-mapped instruction cache with multi-word lines, between IF and the memory controller.
// Latency: a hit returns data 1 cycle after the pc. A miss takes the refill time plus 1 cycle.
// Backpressure: rdy=0 freezes everything. Memory holds each word address until mem_valid. if_valid=0 aborts a refill.
//
// Ports:
//   clk, rst (sync, active-low), rdy (global enable), flush (invalidate all lines + abort refill)
//   if_valid, pc_from_if            : fetch request from IF (pc bits[1:0] ignored)
//   inst_enable, inst_to_if         : registered hit strobe and instruction
//   addr_enable, addr_to_mem        : single-word read request to memory
//   mem_valid, inst_from_mem        : one-cycle word return strobe and data
//   busy                            : high while a line refill is in progress
// Optional macro ICACHE_STATS_EN adds hit_count / miss_count outputs.
module icache_line #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] pc_from_if,
  output logic                  inst_enable,
  output logic [31:0]           inst_to_if,
  output logic                  addr_enable,
  output logic [ADDR_WIDTH-1:0] addr_to_mem,
  input  logic                  mem_valid,
  input  logic [31:0]           inst_from_mem,
  output logic                  busy
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int LINES       = 1 << INDEX_BITS;
  localparam int OFFSET_BITS = $clog2(LINE_WORDS);
  // Counter/offset need at least one bit even for single-word lines.
  localparam int OFF_W       = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
  localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);
  localparam logic [OFF_W-1:0]      LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  // Storage: valid bits are flops with reset, tags and data have no reset.
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES][LINE_WORDS];

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic                  inst_en_q, inst_en_d;
  logic [31:0]           inst_q, inst_d;
  logic                  addr_en_q, addr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;
  logic [INDEX_BITS-1:0] line_idx_q, line_idx_d;
  logic [TAG_BITS-1:0]   line_tag_q, line_tag_d;

  logic                  tag_we;
  logic                  data_we;

  // Address split of the incoming pc.
  logic [ADDR_WIDTH-1:0] pc_word;
  logic [OFF_W-1:0]      pc_off;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [ADDR_WIDTH-1:0] pc_base;
  logic                  hit;

  assign pc_word = pc_from_if >> 2;
  assign pc_off  = OFF_W'(pc_word & OFF_MASK);
  assign pc_idx  = INDEX_BITS'(pc_word >> OFFSET_BITS);
  assign pc_tag  = TAG_BITS'(pc_from_if >> (OFFSET_BITS + INDEX_BITS + 2));
  assign pc_base = pc_from_if & ~LINE_MASK;
  assign hit     = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    inst_en_d  = inst_en_q;
    inst_d     = inst_q;
    addr_en_d  = addr_en_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    line_idx_d = line_idx_q;
    line_tag_d = line_tag_q;
    tag_we     = 1'b0;
    data_we    = 1'b0;

    if (rdy) begin
      if (flush) begin
        // Flush beats a coincident final word: that line stays invalid.
        valid_d   = '0;
        inst_en_d = 1'b0;
        addr_en_d = 1'b0;
        state_d   = IDLE;
      end else if (!if_valid) begin
        inst_en_d = 1'b0;
        if (state_q == REFILL) begin
          // Abort: the line was invalidated at refill start, so the partial words are never hit.
          addr_en_d = 1'b0;
          state_d   = IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (hit) begin
              inst_en_d = 1'b1;
              inst_d    = data_mem[pc_idx][pc_off];
            end else begin
              inst_en_d       = 1'b0;
              valid_d[pc_idx] = 1'b0;
              line_idx_d      = pc_idx;
              line_tag_d      = pc_tag;
              cnt_d           = '0;
              addr_en_d       = 1'b1;
              addr_d          = pc_base;
              state_d         = REFILL;
            end
          end
          REFILL: begin
            inst_en_d = 1'b0;
            if (mem_valid) begin
              data_we = 1'b1;
              if (cnt_q == LAST_WORD) begin
                valid_d[line_idx_q] = 1'b1;
                tag_we              = 1'b1;
                addr_en_d           = 1'b0;
                state_d             = IDLE;
              end else begin
                cnt_d  = cnt_q + OFF_W'(1);
                addr_d = addr_q + ADDR_WIDTH'(4);
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      inst_en_q  <= 1'b0;
      inst_q     <= '0;
      addr_en_q  <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      line_idx_q <= '0;
      line_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      inst_en_q  <= inst_en_d;
      inst_q     <= inst_d;
      addr_en_q  <= addr_en_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      line_idx_q <= line_idx_d;
      line_tag_q <= line_tag_d;
    end
  end

  // Array writes always target the latched line, never the live pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (tag_we)  tag_mem[line_idx_q]         <= line_tag_q;
      if (data_we) data_mem[line_idx_q][cnt_q] <= inst_from_mem;
    end
  end

  assign inst_enable = inst_en_q;
  assign inst_to_if  = inst_q;
  assign addr_enable = addr_en_q;
  assign addr_to_mem = addr_q;
  assign busy        = (state_q == REFILL);

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rdy && inst_en_d)                         hit_cnt_d  = hit_cnt_q + 32'd1;
    if ((state_q == IDLE) && (state_d == REFILL)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
